// File: rtl/idma_pkg.sv
// iDMA shared types for the backend error-handling path.
// Error types, actions, responder modes, log entry and policy helpers.
package idma_pkg;

    typedef enum logic [1:0] {
        BUS_READ  = 2'b00,
        BUS_WRITE = 2'b01,
        BACKEND   = 2'b10,
        ND_MIDEND = 2'b11
    } err_type_t;

    typedef enum logic {
        CONTINUE = 1'b0,
        ABORT    = 1'b1
    } eh_action_e;

    typedef eh_action_e idma_eh_req_t;

    typedef enum logic [1:0] {
        AUTO_CONTINUE = 2'd0,
        AUTO_ABORT    = 2'd1,
        SOFTWARE      = 2'd2
    } eh_mode_e;

    localparam int unsigned ErrLogAddrWidth = 64;

    typedef struct packed {
        err_type_t                  err_type;
        logic [ErrLogAddrWidth-1:0] addr;
    } idma_err_log_t;

    // Only bus errors may be deferred to software.
    function automatic logic needs_sw(err_type_t t, eh_mode_e m);
        return (t == BUS_READ || t == BUS_WRITE) && m == SOFTWARE;
    endfunction

    // Backend/midend faults are never recoverable; unknown modes fail safe.
    function automatic eh_action_e policy_action(err_type_t t, eh_mode_e m);
        if (t == BACKEND || t == ND_MIDEND) return ABORT;
        return (m == AUTO_CONTINUE) ? CONTINUE : ABORT;
    endfunction

endpackage

// File: rtl/idma_eh_log.sv
// Circular error log with sticky overflow flag.
// Ports: push_*/pop_i/clear_i in; valid_o, type_o, addr_o (head), overflow_o out.
module idma_eh_log
    import idma_pkg::*;
#(
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned LogDepth  = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 push_i,
    input  err_type_t            push_type_i,
    input  logic [AddrWidth-1:0] push_addr_i,
    input  logic                 pop_i,
    input  logic                 clear_i,
    output logic                 valid_o,
    output err_type_t            type_o,
    output logic [AddrWidth-1:0] addr_o,
    output logic                 overflow_o
);

    localparam int unsigned PtrWidth = $clog2(LogDepth);

    typedef struct packed {
        err_type_t            err_type;
        logic [AddrWidth-1:0] addr;
    } entry_t;

    entry_t              mem [LogDepth];
    logic [PtrWidth-1:0] rd_ptr;
    logic [PtrWidth-1:0] wr_ptr;
    logic [PtrWidth:0]   fill;
    logic                empty;
    logic                full;
    logic                do_pop;
    logic                do_push;
    entry_t              head;

    assign empty   = fill == '0;
    assign full    = fill == (PtrWidth+1)'(LogDepth);
    assign do_pop  = pop_i && !empty;
    // A pop frees the slot in the same cycle, so a full log can still take the push.
    assign do_push = push_i && (!full || do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fill       <= '0;
            overflow_o <= 1'b0;
        end else if (clear_i) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fill       <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            fill <= fill + (PtrWidth+1)'(do_push)
                         - (PtrWidth+1)'(do_pop);
            if (push_i && !do_push) overflow_o <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !clear_i) begin
            mem[wr_ptr] <= entry_t'{err_type: push_type_i,
                                    addr: push_addr_i};
        end
    end

    assign head    = mem[rd_ptr];
    assign valid_o = !empty;
    assign type_o  = empty ? BUS_READ : head.err_type;
    assign addr_o  = empty ? '0 : head.addr;

endmodule

// File: rtl/idma_eh_responder.sv
// iDMA error-handling responder: one CONTINUE/ABORT action per backend error report.
// Ports: err_* report in, eh_* action out, sw_* decision in, pend_*/log_*/count status out.
module idma_eh_responder
    import idma_pkg::*;
#(
    parameter int unsigned AddrWidth     = 64,
    parameter int unsigned LogDepth      = 4,
    parameter int unsigned CntWidth      = 16,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 err_valid_i,
    output logic                 err_ready_o,
    input  err_type_t            err_type_i,
    input  logic [AddrWidth-1:0] err_addr_i,
    output logic                 eh_valid_o,
    input  logic                 eh_ready_i,
    output idma_eh_req_t         eh_o,
    input  eh_mode_e             mode_i,
    input  logic                 sw_valid_i,
    input  eh_action_e           sw_action_i,
    output logic                 pending_o,
    output err_type_t            pend_type_o,
    output logic [AddrWidth-1:0] pend_addr_o,
    output logic                 log_valid_o,
    output err_type_t            log_type_o,
    output logic [AddrWidth-1:0] log_addr_o,
    input  logic                 log_pop_i,
    output logic                 overflow_o,
    output logic [CntWidth-1:0]  err_count_o,
    input  logic                 clear_i,
    output logic                 busy_o
);

    localparam int unsigned TimerWidth =
        (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam logic [TimerWidth-1:0] TimerLast =
        TimerWidth'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ISSUE
    } state_e;

    state_e                state_q;
    state_e                state_d;
    eh_action_e            action_q;
    eh_action_e            action_d;
    logic [TimerWidth-1:0] timer_q;
    logic [TimerWidth-1:0] timer_d;
    err_type_t             type_q;
    logic [AddrWidth-1:0]  addr_q;
    logic [CntWidth-1:0]   count_q;
    logic                  accept;
    logic                  expired;

    assign accept  = err_valid_i && state_q == IDLE;
    assign expired = (TimeoutCycles != 0) && timer_q == TimerLast;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        action_d    = action_q;
        timer_d     = timer_q;
        err_ready_o = 1'b0;
        eh_valid_o  = 1'b0;
        pending_o   = 1'b0;
        unique case (state_q)
            IDLE: begin
                err_ready_o = 1'b1;
                if (err_valid_i) begin
                    if (needs_sw(err_type_i, mode_i)) begin
                        state_d = WAIT;
                        timer_d = '0;
                    end else begin
                        state_d  = ISSUE;
                        action_d = policy_action(err_type_i, mode_i);
                    end
                end
            end
            WAIT: begin
                pending_o = 1'b1;
                timer_d   = timer_q + 1'b1;
                // Software beats a same-cycle timeout.
                if (sw_valid_i) begin
                    state_d  = ISSUE;
                    action_d = sw_action_i;
                end else if (expired) begin
                    state_d  = ISSUE;
                    action_d = ABORT;
                end
            end
            ISSUE: begin
                eh_valid_o = 1'b1;
                if (eh_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            action_q <= CONTINUE;
            timer_q  <= '0;
            type_q   <= BUS_READ;
            addr_q   <= '0;
        end else begin
            action_q <= action_d;
            timer_q  <= timer_d;
            if (accept) begin
                type_q <= err_type_i;
                addr_q <= err_addr_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (accept && count_q != '1) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign eh_o        = (state_q == ISSUE) ? action_q : CONTINUE;
    assign busy_o      = state_q != IDLE;
    assign pend_type_o = pending_o ? type_q : BUS_READ;
    assign pend_addr_o = pending_o ? addr_q : '0;
    assign err_count_o = count_q;

    idma_eh_log #(
        .AddrWidth (AddrWidth),
        .LogDepth  (LogDepth)
    ) i_log (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (accept),
        .push_type_i (err_type_i),
        .push_addr_i (err_addr_i),
        .pop_i       (log_pop_i),
        .clear_i     (clear_i),
        .valid_o     (log_valid_o),
        .type_o      (log_type_o),
        .addr_o      (log_addr_o),
        .overflow_o  (overflow_o)
    );

endmodule
